// File: rtl/rom_sync_rd.sv
// rom_sync_rd: 256 x 8 fixed lookup table with a registered read port.
// Entries 0..15 hold the square of the address. Entries 16..255 hold 8'hFF minus the address.
// A read issued on one edge presents its data and a valid flag after that same edge.
module rom_sync_rd #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] direccion,
  output logic [7:0] dato_s,
  output logic       valido
);

  // Table contents as a pure function of the address, so synthesis folds it into LUT/ROM logic.
  function automatic logic [7:0] rom_entry(input logic [7:0] addr);
    logic [7:0] val;
    case (addr)
      8'd0:    val = 8'd0;
      8'd1:    val = 8'd1;
      8'd2:    val = 8'd4;
      8'd3:    val = 8'd9;
      8'd4:    val = 8'd16;
      8'd5:    val = 8'd25;
      8'd6:    val = 8'd36;
      8'd7:    val = 8'd49;
      8'd8:    val = 8'd64;
      8'd9:    val = 8'd81;
      8'd10:   val = 8'd100;
      8'd11:   val = 8'd121;
      8'd12:   val = 8'd144;
      8'd13:   val = 8'd169;
      8'd14:   val = 8'd196;
      8'd15:   val = 8'd225;
      default: val = 8'hFF - addr;
    endcase
    return val;
  endfunction

  logic [7:0] rd_data_c;

  // Combinational table lookup. It is only captured when en is high, so X on an idle address stays out of dato_s.
  always_comb begin
    rd_data_c = rom_entry(direccion);
  end

  // Registered read port. Reset wins over a read on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dato_s <= RESET_VAL;
      valido <= 1'b0;
    end else begin
      valido <= en;
      if (en) begin
        dato_s <= rd_data_c;
      end
    end
  end

endmodule

// File: tb/tb_rom_sync_rd.sv
// Scoreboard bench for rom_sync_rd: the driver queues the expected result for each edge, and the monitor pops it and compares.
module tb_rom_sync_rd;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] direccion;
  logic [7:0] dato_s;
  logic       valido;

  typedef struct {
    logic [7:0] d;
    logic       v;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  rom_sync_rd #(.RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .direccion (direccion),
    .dato_s    (dato_s),
    .valido    (valido)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference for the sweep
  function automatic logic [7:0] ref_rom(input int a);
    if (a < 16) return 8'(a * a);
    return 8'(255 - a);
  endfunction

  // Drive one edge's inputs and queue what the outputs must show after that edge
  task automatic step(input logic r, input logic e, input logic [7:0] a,
                      input logic [7:0] ed, input logic ev, input string nm);
    exp_t x;
    rst_n = r;
    en = e;
    direccion = a;
    x.d = ed;
    x.v = ev;
    x.name = nm;
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  // Monitor: sample mid-cycle and check against the oldest queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      if (dato_s !== x.d || valido !== x.v)
        $display("FAIL %s: got dato_s=%0d valido=%b, expected dato_s=%0d valido=%b",
                 x.name, dato_s, valido, x.d, x.v);
      else
        passes++;
    end
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    direccion = 8'd0;

    // 1. reset and release with en low
    step(1'b0, 1'b0, 8'd0,  8'd0, 1'b0, "reset_0");
    step(1'b0, 1'b1, 8'd77, 8'd0, 1'b0, "reset_1");
    step(1'b1, 1'b0, 8'd55, 8'd0, 1'b0, "release");

    // 2. squares region
    step(1'b1, 1'b1, 8'd0,  8'd0,   1'b1, "rd_0");
    step(1'b1, 1'b1, 8'd3,  8'd9,   1'b1, "rd_3");
    step(1'b1, 1'b1, 8'd6,  8'd36,  1'b1, "rd_6");
    step(1'b1, 1'b1, 8'd9,  8'd81,  1'b1, "rd_9");
    step(1'b1, 1'b1, 8'd10, 8'd100, 1'b1, "rd_10");
    step(1'b1, 1'b1, 8'd15, 8'd225, 1'b1, "rd_15");

    // 3. formula boundary
    step(1'b1, 1'b1, 8'd15,  8'd225, 1'b1, "bnd_15");
    step(1'b1, 1'b1, 8'd16,  8'd239, 1'b1, "bnd_16");
    step(1'b1, 1'b1, 8'd17,  8'd238, 1'b1, "bnd_17");
    step(1'b1, 1'b1, 8'd255, 8'd0,   1'b1, "bnd_255");

    // 4. hold, including X on an idle address
    step(1'b1, 1'b1, 8'd9,   8'd81, 1'b1, "hold_rd9");
    step(1'b1, 1'b0, 8'd200, 8'd81, 1'b0, "hold_200");
    step(1'b1, 1'b0, 8'hxx,  8'd81, 1'b0, "hold_x");

    // 5. reset mid-stream discards the simultaneous read
    step(1'b0, 1'b1, 8'd10, 8'd0,   1'b0, "midrst");
    step(1'b1, 1'b1, 8'd10, 8'd100, 1'b1, "midrst_rd10");

    // 6. back-to-back sweep of every address
    for (int a = 0; a < 256; a++)
      step(1'b1, 1'b1, 8'(a), ref_rom(a), 1'b1, $sformatf("sweep_%0d", a));
    step(1'b1, 1'b0, 8'd3, 8'd0, 1'b0, "sweep_idle");

    // Bounded drain of the scoreboard
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0)
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    else
      passes++;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
